// File: rtl/fetch_queue_if.sv
// Handshake bundle between a fetch unit (master) and the fetch queue (slave).
// Carries the paired enqueue slots and the paired head/head+1 dequeue view.
interface fetch_queue_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic [1:0]        enq_valid;
   logic [ADDR_W-1:0] enq_pc0;
   logic [ADDR_W-1:0] enq_pc1;
   logic [DATA_W-1:0] enq_instr0;
   logic [DATA_W-1:0] enq_instr1;
   logic              enq_ready;
   logic [1:0]        deq_valid;
   logic [ADDR_W-1:0] deq_pc0;
   logic [ADDR_W-1:0] deq_pc1;
   logic [DATA_W-1:0] deq_instr0;
   logic [DATA_W-1:0] deq_instr1;
   logic [1:0]        deq_req;

   modport master (
      output enq_valid, enq_pc0, enq_pc1, enq_instr0, enq_instr1, deq_req,
      input  enq_ready, deq_valid, deq_pc0, deq_pc1, deq_instr0, deq_instr1
   );

   modport slave (
      input  enq_valid, enq_pc0, enq_pc1, enq_instr0, enq_instr1, deq_req,
      output enq_ready, deq_valid, deq_pc0, deq_pc1, deq_instr0, deq_instr1
   );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue circular fetch queue: up to two entries in and two out per cycle.
// Define FQ_BYPASS_EN to let an enqueue into an empty queue appear on deq outputs same cycle.
module fetch_queue #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   fetch_queue_if.slave             fq_io,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     ovf_err_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [DATA_W-1:0] instr_mem [DEPTH];

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          enq_legal, deq_legal, enq_ok, byp_en;
   logic [1:0]    n_enq, n_deq, n_skip, n_wr, n_pop, deq_take;
   logic [ADDR_W-1:0] wr_pc0;
   logic [DATA_W-1:0] wr_instr0;

   assign head_p1         = head_q + PW'(1);
   assign tail_p1         = tail_q + PW'(1);
   assign fq_io.enq_ready = (count_q <= CW'(DEPTH - 2));
   assign enq_legal       = (fq_io.enq_valid == 2'b01) || (fq_io.enq_valid == 2'b11);
   assign deq_legal       = (fq_io.deq_req != 2'b10);
   assign enq_ok          = enq_legal && fq_io.enq_ready && !flush_i;
   assign n_enq           = enq_ok ? (fq_io.enq_valid[1] ? 2'd2 : 2'd1) : 2'd0;

`ifdef FQ_BYPASS_EN
   assign byp_en = enq_ok && (count_q == '0);
`else
   assign byp_en = 1'b0;
`endif

   // Dequeue view: bypassed enqueue slots when empty, otherwise stored head/head+1.
   always_comb begin
      if (byp_en) begin
         fq_io.deq_valid  = fq_io.enq_valid;
         fq_io.deq_pc0    = fq_io.enq_pc0;
         fq_io.deq_pc1    = fq_io.enq_pc1;
         fq_io.deq_instr0 = fq_io.enq_instr0;
         fq_io.deq_instr1 = fq_io.enq_instr1;
      end else begin
         fq_io.deq_valid  = {count_q >= CW'(2), count_q != '0};
         fq_io.deq_pc0    = pc_mem[head_q];
         fq_io.deq_pc1    = pc_mem[head_p1];
         fq_io.deq_instr0 = instr_mem[head_q];
         fq_io.deq_instr1 = instr_mem[head_p1];
      end
   end

   assign deq_take = deq_legal ? (fq_io.deq_req & fq_io.deq_valid) : 2'b00;
   assign n_deq    = {1'b0, deq_take[0]} + {1'b0, deq_take[1]};

   // Bypassed entries consumed this cycle are never written; the rest shift down one slot.
   assign n_skip    = byp_en ? n_deq : 2'd0;
   assign n_pop     = byp_en ? 2'd0 : n_deq;
   assign n_wr      = n_enq - n_skip;
   assign wr_pc0    = n_skip[0] ? fq_io.enq_pc1 : fq_io.enq_pc0;
   assign wr_instr0 = n_skip[0] ? fq_io.enq_instr1 : fq_io.enq_instr0;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q
              | (fq_io.enq_valid == 2'b10)
              | !deq_legal
              | ((fq_io.enq_valid != 2'b00) && !fq_io.enq_ready);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(n_pop);
         tail_d  = tail_q + PW'(n_wr);
         count_d = count_q + CW'(n_wr) - CW'(n_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (n_wr != 2'd0) begin
         pc_mem[tail_q]    <= wr_pc0;
         instr_mem[tail_q] <= wr_instr0;
      end
      if (n_wr == 2'd2) begin
         pc_mem[tail_p1]    <= fq_io.enq_pc1;
         instr_mem[tail_p1] <= fq_io.enq_instr1;
      end
   end

   assign count_o   = count_q;
   assign ovf_err_o = ovf_q;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter DEPTH, default 8, entry count; power of two, minimum 4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all entries (branch/exception redirect).
REQ-007 enq_valid  input  2  slot-valid mask for incoming pair; only 00, 01 and 11 are legal.
REQ-008 enq_pc0, enq_pc1  input  ADDR_W each  PCs of incoming slots 0 and 1.
REQ-009 enq_instr0, enq_instr1  input  DATA_W each  instructions from the master and slave imem ports.
REQ-010 enq_ready  output  1  high when at least 2 entries are free.
REQ-011 deq_valid  output  2  bit0 high when head entry is present; bit1 high when head+1 entry is present.
REQ-012 deq_pc0, deq_instr0, deq_pc1, deq_instr1  output  ADDR_W/DATA_W  head and head+1 contents.
REQ-013 deq_req  input  2  consumer take mask; only 00, 01 and 11 are legal.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 ovf_err  output  1  sticky overflow/illegal-mask flag.

Function
REQ-016 The queue SHALL be circular, with head and tail pointers wrapping modulo DEPTH.
REQ-017 An enqueue SHALL be accepted when enq_ready=1 and enq_valid is nonzero: slot0 is written at tail, slot1 at tail+1 if valid, and tail advances by popcount(enq_valid).
REQ-018 enq_ready SHALL derive from the registered count only, giving DEPTH-count>=2 with no same-cycle dequeue credit.
REQ-019 A nonzero enq_valid with enq_ready=0 SHALL be dropped and SHALL set ovf_err.
REQ-020 enq_valid=10 or deq_req=10 SHALL be ignored and SHALL set ovf_err.
REQ-021 deq outputs SHALL be combinational reads of head and head+1.
REQ-022 deq_valid SHALL be {count>=2, count>=1}; deq_pc/deq_instr SHALL be don't-care when the matching valid bit is 0.
REQ-023 Dequeue SHALL remove deq_req & deq_valid entries: head advances by 0, 1 or 2.
REQ-024 A request for an entry that is not valid SHALL be silently clipped: 11 with count=1 removes 1 entry.
REQ-025 Simultaneous enqueue and dequeue SHALL be allowed: count_next = count + n_enq - n_deq, never exceeding DEPTH and never negative.
REQ-026 Enqueue-to-deq_valid latency SHALL be 1 cycle when FQ_BYPASS_EN is undefined.
REQ-027 Program order SHALL be preserved: enq slot0 precedes slot1, and earlier cycles precede later ones.
REQ-028 flush=1 SHALL take priority on the next edge: head=tail=0 and count=0.
REQ-029 During flush, same-cycle enq and deq SHALL have no effect.
REQ-030 flush SHALL NOT clear ovf_err.
REQ-031 Wrap-around SHALL be seamless: a pair written at tail=DEPTH-1 places slot1 at index 0.

Reset
REQ-032 rst=0 SHALL asynchronously force head=0, tail=0, count=0 and ovf_err=0.
REQ-033 During reset, deq_valid=00 and enq_ready=1.
REQ-034 Storage contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-036 The first enqueue SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-037 The macro FQ_BYPASS_EN, when defined, SHALL enable an empty-queue bypass. With count=0 and a legal enqueue, deq_valid/deq_pc/deq_instr reflect the enq inputs in the same cycle. Bypassed entries taken by deq_req are not written to the queue; untaken entries are written.
REQ-038 When FQ_BYPASS_EN is undefined, deq outputs SHALL reflect stored entries only.
REQ-039 With bypass enabled, the bypass SHALL be inactive whenever count>0 or flush=1.

Verification
REQ-040 Reset, then enq 11 with PCs 0x0/0x4, deq_req 00 -> next cycle count=2, deq_valid=11, deq_pc0=0x0, deq_pc1=0x4.
REQ-041 Fill DEPTH=8 with 4 pairs, PCs 0x0..0x1C -> enq_ready=0 at count=8; a further enq 11 -> dropped, ovf_err=1, count stays 8.
REQ-042 count=1, enq 11 plus deq_req 11 in the same cycle -> one entry removed, two added, count=2, order intact.
REQ-043 Drive head/tail through 3 full wraps with pairs straddling index 7->0 -> PCs dequeue strictly ascending by 4.
REQ-044 count=5, flush=1 with enq 11 in the same cycle -> count=0, deq_valid=00 next cycle; ovf_err unchanged.
REQ-045 With FQ_BYPASS_EN defined, empty queue, enq 11 (0x40/0x44) plus deq_req 01 in the same cycle -> deq_pc0=0x40 in that cycle, count=1 next cycle with head PC 0x44.
